nvram_io: RTL and testbench

Bidirectional save-RAM transfer engine between the HPS ioctl channel and a game-side battery/NVRAM dual-port RAM. It serves HPS upload requests (RAM → HPS, `ioctl_rd`/`ioctl_din`) and restores saved contents on download (HPS → RAM, `ioctl_wr`/`ioctl_dout`). While a transfer runs it pauses the game CPU and throttles the HPS with `ioctl_wait`. It sits in `emu` next to the ROM loader and claims one `ioctl_index`.

---
 rtl/nvram_io.sv | 219 +++++++++++++++++++++
 tb/tb_nvram_io.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_io.sv
// nvram_io: moves the battery/NVRAM save RAM to and from the HPS ioctl channel.
// An upload reads the RAM out to the HPS over ioctl_rd/ioctl_din. A download
// writes HPS data into the RAM over ioctl_wr/ioctl_dout. While a session is
// open the game CPU is paused, and ioctl_wait stalls the HPS during settling
// and during each read.
// Optional feature macro: NVRAM_DIRTY_EN. When it is defined, a game-side
// write sets the dirty flag and a completed upload clears it. When it is not
// defined, dirty is held at 0 and game_we is ignored.
//
// Handshake: the HPS may issue an ioctl_rd/ioctl_wr strobe only while
// ioctl_wait is low. Each strobe is a single-cycle request and is never
// back-pressured once accepted. Writes complete in the strobe cycle. Read data
// is valid on ioctl_din when ioctl_wait falls again.
// dbg_state exposes the FSM state so that checkers can observe it.
module nvram_io #(
    parameter int          AW     = 10,
    parameter logic [7:0]  INDEX  = 8'd4,
    parameter int          SETTLE = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic          ioctl_rd,
    input  logic          ioctl_wr,
    input  logic [7:0]    ioctl_dout,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_d,
    input  logic [7:0]    ram_q,
    output logic          pause_cpu,
    output logic          busy,
    input  logic          game_we,
    output logic          dirty,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_READY  = 3'd2,
        S_FETCH  = 3'd3,
        S_LATCH  = 3'd4
    } state_t;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          oor_q, oor_d;
    logic [7:0]    din_q, din_d;
    logic          wait_q, wait_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          pause_q, pause_d;
    logic          busy_q, busy_d;
    logic          dirty_q, dirty_d;

    logic sess;
    logic addr_oor;
    logic upload_done;

    // A session is open only while the HPS targets this block's index.
    assign sess     = (ioctl_upload | ioctl_download) & (ioctl_index == INDEX);
    assign addr_oor = |ioctl_addr[24:AW];

    // Next-state, transfer and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        oor_d       = oor_q;
        din_d       = din_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        wdat_d      = wdat_q;
        pause_d     = pause_q;
        upload_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sess) begin
                    state_d = S_SETTLE;
                    pause_d = 1'b1;
                    wait_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                    dir_d   = ioctl_upload;
                end
            end
            S_SETTLE: begin
                if (!sess) begin
                    // An abandoned session before READY releases everything.
                    state_d = S_IDLE;
                    pause_d = 1'b0;
                    wait_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = S_READY;
                    wait_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_READY: begin
                if (!sess) begin
                    state_d     = S_IDLE;
                    pause_d     = 1'b0;
                    upload_done = dir_q;
                end else if (dir_q && ioctl_rd) begin
                    state_d = S_FETCH;
                    wait_d  = 1'b1;
                    oor_d   = addr_oor;
                    // An out-of-range read leaves the RAM address alone
                    // so that it never wraps onto a real location.
                    if (!addr_oor) begin
                        addr_d = ioctl_addr[AW-1:0];
                    end
                end else if (!dir_q && ioctl_wr && !addr_oor) begin
                    we_d   = 1'b1;
                    addr_d = ioctl_addr[AW-1:0];
                    wdat_d = ioctl_dout;
                end
            end
            S_FETCH: begin
                // The RAM output register is filled at the end of this cycle.
                state_d = S_LATCH;
            end
            S_LATCH: begin
                din_d  = oor_q ? 8'hFF : ram_q;
                wait_d = 1'b0;
                if (sess) begin
                    state_d = S_READY;
                end else begin
                    state_d     = S_IDLE;
                    pause_d     = 1'b0;
                    upload_done = dir_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                pause_d = 1'b0;
                wait_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef NVRAM_DIRTY_EN
    // Dirty tracking: a game write sets the flag, and a finished upload clears it. Set wins.
    always_comb begin
        dirty_d = dirty_q;
        if (game_we && !pause_q) begin
            dirty_d = 1'b1;
        end else if (upload_done) begin
            dirty_d = 1'b0;
        end
    end
`else
    logic unused_game_we;
    logic unused_upload_done;
    assign unused_game_we     = game_we;
    assign unused_upload_done = upload_done;

    // Dirty tracking is disabled in this build.
    always_comb begin
        dirty_d = 1'b0;
    end
`endif

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            oor_q   <= 1'b0;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdat_q  <= 8'h00;
            pause_q <= 1'b0;
            busy_q  <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            oor_q   <= oor_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            pause_q <= pause_d;
            busy_q  <= busy_d;
            dirty_q <= dirty_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign ram_addr   = addr_q;
    assign ram_we     = we_q;
    assign ram_d      = wdat_q;
    assign pause_cpu  = pause_q;
    assign busy       = busy_q;
    assign dirty      = dirty_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_nvram_io.sv
// Testbench for nvram_io. It uses directed session steps plus randomized
// download and upload traffic. The expected values come from a byte-array
// model of the save region.
module tb_nvram_io;

    localparam int         AW     = 10;
    localparam logic [7:0] IDX    = 8'd4;
    localparam int         SETTLE = 4;
    localparam int         DEPTH  = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          ioctl_upload = 1'b0;
    logic          ioctl_download = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic [24:0]   ioctl_addr = '0;
    logic          ioctl_rd = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [7:0]    ioctl_dout = 8'd0;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_d;
    logic [7:0]    ram_q;
    logic          pause_cpu;
    logic          busy;
    logic          game_we = 1'b0;
    logic          dirty;
    logic [2:0]    dbg_state;

    nvram_io #(.AW(AW), .INDEX(IDX), .SETTLE(SETTLE)) dut (
        .clk_sys(clk), .reset(reset),
        .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
        .pause_cpu(pause_cpu), .busy(busy),
        .game_we(game_we), .dirty(dirty), .dbg_state(dbg_state)
    );

    // ---------------- dual-port RAM environment ----------------
    logic [7:0]    mem [0:DEPTH-1];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [7:0]    pl_data = 8'd0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] ref_mem [DEPTH];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_din"},   32'(ioctl_din), 32'h00);
        chk({tag, "_wait"},  32'(ioctl_wait), 0);
        chk({tag, "_we"},    32'(ram_we), 0);
        chk({tag, "_addr"},  32'(ram_addr), 0);
        chk({tag, "_d"},     32'(ram_d), 0);
        chk({tag, "_pause"}, 32'(pause_cpu), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_dirty"}, 32'(dirty), 0);
    endtask

    // Open a session and check its framing. The wait signal stays high for SETTLE cycles and then falls.
    task automatic open_sess(input bit up);
        ioctl_index    = IDX;
        ioctl_upload   = up;
        ioctl_download = !up;
        tick();
        chk("start_pause", 32'(pause_cpu), 1);
        chk("start_wait",  32'(ioctl_wait), 1);
        chk("start_busy",  32'(busy), 1);
        for (int i = 1; i < SETTLE; i++) begin
            tick();
            chk("settle_wait", 32'(ioctl_wait), 1);
        end
        tick();
        chk("ready_wait",  32'(ioctl_wait), 0);
        chk("ready_pause", 32'(pause_cpu), 1);
    endtask

    task automatic close_sess();
        ioctl_upload   = 1'b0;
        ioctl_download = 1'b0;
        tick();
        chk("end_pause", 32'(pause_cpu), 0);
        chk("end_busy",  32'(busy), 0);
        chk("end_wait",  32'(ioctl_wait), 0);
    endtask

    // Upload read: wait is high for two cycles, then the data is valid.
    task automatic do_read(input logic [24:0] addr);
        logic [7:0] exp;
        exp = (addr < 25'(DEPTH)) ? ref_mem[addr[AW-1:0]] : 8'hFF;
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        chk("rd_wait1", 32'(ioctl_wait), 1);
        tick();
        chk("rd_wait2", 32'(ioctl_wait), 1);
        chk("rd_nowe",  32'(ram_we), 0);
        tick();
        chk("rd_wait_low", 32'(ioctl_wait), 0);
        chk("rd_data",     32'(ioctl_din), 32'(exp));
    endtask

    // Download write: one single-cycle ram_we pulse for an in-range address.
    task automatic do_write(input logic [24:0] addr, input logic [7:0] data);
        bit in_range;
        in_range   = (addr < 25'(DEPTH));
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        tick();
        chk("wr_we", 32'(ram_we), 32'(in_range));
        if (in_range) begin
            chk("wr_addr", 32'(ram_addr), 32'(addr[AW-1:0]));
            chk("wr_data", 32'(ram_d), 32'(data));
            ref_mem[addr[AW-1:0]] = data;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] v;
        // Preload the RAM and the model while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            v = 8'($urandom);
            if (i == 5) v = 8'hA5;
            pl_we = 1'b1; pl_addr = AW'(i); pl_data = v;
            ref_mem[i] = v;
        end
        tick();
        pl_we = 1'b0;
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick();
        chk_reset_outputs("post_rst");

        // Upload after preload, including an out-of-range read and a stray write strobe.
        open_sess(1'b1);
        do_read(25'h005);
        do_read(25'h400);
        ioctl_wr = 1'b1; ioctl_addr = 25'h007; ioctl_dout = 8'h5A;
        tick();
        ioctl_wr = 1'b0;
        chk("up_ignores_wr", 32'(ram_we), 0);
        close_sess();

        // A wrong index never opens a session.
        ioctl_index = 8'd0; ioctl_upload = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wrong_idx_busy",  32'(busy), 0);
            chk("wrong_idx_pause", 32'(pause_cpu), 0);
            chk("wrong_idx_we",    32'(ram_we), 0);
        end
        ioctl_upload = 1'b0;
        tick();

        // Download burst on consecutive cycles, followed by an out-of-range write.
        open_sess(1'b0);
        do_write(25'h0, 8'h11);
        do_write(25'h1, 8'h22);
        do_write(25'h2, 8'h33);
        do_write(25'h3, 8'h44);
        ioctl_wr = 1'b0;
        tick();
        chk("burst_we_end", 32'(ram_we), 0);
        do_write(25'h400, 8'h99);
        ioctl_wr = 1'b0;
        tick();
        close_sess();

        // Randomized download followed by a randomized upload readback.
        open_sess(1'b0);
        for (int i = 0; i < 40; i++) begin
            do_write(25'($urandom_range(0, DEPTH + 255)), 8'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                ioctl_wr = 1'b0;
                tick();
            end
        end
        ioctl_wr = 1'b0;
        tick();
        close_sess();
        open_sess(1'b1);
        do_read(25'h0);
        do_read(25'h3);
        for (int i = 0; i < 30; i++) do_read(25'($urandom_range(0, DEPTH + 255)));
        close_sess();

        // Async reset during FETCH, then a normal session afterwards.
        open_sess(1'b1);
        ioctl_addr = 25'h005; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        chk("fetch_wait", 32'(ioctl_wait), 1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        ioctl_upload = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_idle_busy", 32'(busy), 0);
        open_sess(1'b1);
        do_read(25'h005);
        close_sess();

`ifdef NVRAM_DIRTY_EN
        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        chk("dirty_set", 32'(dirty), 1);
        open_sess(1'b1);
        do_read(25'h001);
        chk("dirty_hold_in_sess", 32'(dirty), 1);
        close_sess();
        chk("dirty_clr", 32'(dirty), 0);
        open_sess(1'b0);
        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        chk("dirty_paused", 32'(dirty), 0);
        close_sess();
        chk("dirty_after_dl", 32'(dirty), 0);
`else
        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        tick();
        chk("dirty_off", 32'(dirty), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
